z80_bus_responder: RTL and testbench

- Target-side responder for the Z80 external bus. It serves the memory, I/O and interrupt-acknowledge cycles that the CPU core initiates.
- Decodes nMREQ/nIORQ/nRD/nWR/nM1/nRFSH and converts each bus cycle into a single req/ack transaction on a memory port or an I/O port.
- Inserts wait states with nWAIT and drives D during read cycles.
- Sits between the CPU top and the simulation/system RAM and port models (zexall bench, later the system bus fabric).

---
 rtl/z80_bus_pkg.sv | 40 ++++
 rtl/z80_cycle_decode.sv | 37 +++
 rtl/z80_bus_responder.sv | 176 +++++++++++++++++
 tb/tb_z80_bus_responder.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/z80_bus_pkg.sv
//------------------------------------------------------------------------------
// Module  : z80_bus_pkg
// Brief   : Shared cycle/state types and constants for the Z80 bus responder.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package z80_bus_pkg;

  typedef enum logic [2:0] {
    CYC_NONE,
    CYC_MEMRD,
    CYC_MEMWR,
    CYC_IORD,
    CYC_IOWR,
    CYC_INTA
  } cyc_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAITCNT,
    ST_READY,
    ST_INTA,
    ST_ABORT
  } state_t;

  localparam logic [7:0] INTA_DEF = 8'hFF;

  function automatic logic isMemCyc(input cyc_t c);
    return (c == CYC_MEMRD) || (c == CYC_MEMWR);
  endfunction

  function automatic logic isReadCyc(input cyc_t c);
    return (c == CYC_MEMRD) || (c == CYC_IORD);
  endfunction

endpackage

`default_nettype wire

// File: rtl/z80_cycle_decode.sv
//------------------------------------------------------------------------------
// Module  : z80_cycle_decode
// Brief   : Combinational classification of Z80 control strobes into a cycle type.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module z80_cycle_decode
  import z80_bus_pkg::*;
(
  input  logic nM1,
  input  logic nMREQ,
  input  logic nIORQ,
  input  logic nRD,
  input  logic nWR,
  input  logic nRFSH,
  output cyc_t cyc
);

  // Memory strobes win over I/O when both are (illegally) asserted together.
  always_comb begin
    cyc = CYC_NONE;
    if (!nMREQ && !nRD && nRFSH)
      cyc = CYC_MEMRD;
    else if (!nMREQ && !nWR)
      cyc = CYC_MEMWR;
    else if (!nIORQ && !nM1)
      cyc = CYC_INTA;
    else if (!nIORQ && !nRD)
      cyc = CYC_IORD;
    else if (!nIORQ && !nWR)
      cyc = CYC_IOWR;
  end

endmodule

`default_nettype wire

// File: rtl/z80_bus_responder.sv
//------------------------------------------------------------------------------
// Module  : z80_bus_responder
// Brief   : Target-side Z80 bus responder turning bus cycles into req/ack transfers.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module z80_bus_responder
  import z80_bus_pkg::*;
#(
  parameter int         MEM_WAIT       = 1,
  parameter int         IO_WAIT        = 0,
  parameter logic [7:0] INT_VECTOR_DEF = INTA_DEF
) (
  input  logic        CLK,
  input  logic        nRESET,
  input  logic [15:0] A,
  inout  wire  [7:0]  D,
  input  logic        nM1,
  input  logic        nMREQ,
  input  logic        nIORQ,
  input  logic        nRD,
  input  logic        nWR,
  input  logic        nRFSH,
  output logic        nWAIT,
  output logic        mem_req,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata,
  input  logic        mem_ack,
  output logic        io_req,
  output logic        io_we,
  output logic [7:0]  io_addr,
  output logic [7:0]  io_wdata,
  input  logic [7:0]  io_rdata,
  input  logic        io_ack,
  input  logic [7:0]  int_vec,
  input  logic        int_vec_en,
  output logic        intack
);

  localparam logic [3:0] C_MEM_WAIT = 4'(MEM_WAIT);
  localparam logic [3:0] C_IO_WAIT  = 4'(IO_WAIT);

  cyc_t       w_cyc;
  state_t     r_state;
  cyc_t       r_cyc;
  logic [7:0] r_rdBuf;
  logic [7:0] r_vec;
  logic [3:0] r_cnt;

  logic       w_newAccess;
  logic       w_cycleEnded;
  logic       w_busy;
  logic       w_ack;
  logic [7:0] w_rdata;
  logic [3:0] w_waitLoad;
  logic       w_dOe;

  z80_cycle_decode u_decode (
    .nM1   (nM1),
    .nMREQ (nMREQ),
    .nIORQ (nIORQ),
    .nRD   (nRD),
    .nWR   (nWR),
    .nRFSH (nRFSH),
    .cyc   (w_cyc)
  );

  assign w_newAccess  = (w_cyc == CYC_MEMRD) || (w_cyc == CYC_MEMWR) ||
                        (w_cyc == CYC_IORD)  || (w_cyc == CYC_IOWR);
  assign w_cycleEnded = (nMREQ && nIORQ) || (nRD && nWR);
  assign w_ack        = isMemCyc(r_cyc) ? mem_ack   : io_ack;
  assign w_rdata      = isMemCyc(r_cyc) ? mem_rdata : io_rdata;
  assign w_waitLoad   = isMemCyc(r_cyc) ? C_MEM_WAIT : C_IO_WAIT;

  // Wait is raised already in the IDLE cycle where the access is first seen,
  // so the CPU samples it at the T2 falling edge.
  assign w_busy = (r_state == ST_IDLE) ? w_newAccess :
                  (((r_state == ST_REQ) || (r_state == ST_WAITCNT)) && !w_cycleEnded);
  assign nWAIT  = !(nRESET && w_busy);

  assign w_dOe = ((r_state == ST_READY) && isReadCyc(r_cyc) && !nRD) ||
                 ((r_state == ST_INTA) && !nIORQ);
  assign D     = w_dOe ? ((r_state == ST_INTA) ? r_vec : r_rdBuf) : 8'hzz;

  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      r_state   <= ST_IDLE;
      r_cyc     <= CYC_NONE;
      r_rdBuf   <= 8'h00;
      r_vec     <= 8'h00;
      r_cnt     <= 4'd0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= 16'h0000;
      mem_wdata <= 8'h00;
      io_req    <= 1'b0;
      io_we     <= 1'b0;
      io_addr   <= 8'h00;
      io_wdata  <= 8'h00;
      intack    <= 1'b0;
    end else begin
      intack <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_newAccess) begin
            r_cyc   <= w_cyc;
            r_state <= ST_REQ;
            if (isMemCyc(w_cyc)) begin
              mem_addr <= A;
              mem_we   <= (w_cyc == CYC_MEMWR);
              mem_req  <= 1'b1;
              if (w_cyc == CYC_MEMWR)
                mem_wdata <= D;
            end else begin
              io_addr <= A[7:0];
              io_we   <= (w_cyc == CYC_IOWR);
              io_req  <= 1'b1;
              if (w_cyc == CYC_IOWR)
                io_wdata <= D;
            end
          end else if (w_cyc == CYC_INTA) begin
            r_cyc   <= CYC_INTA;
            r_vec   <= int_vec_en ? int_vec : INT_VECTOR_DEF;
            intack  <= 1'b1;
            r_state <= ST_INTA;
          end
        end
        ST_REQ: begin
          if (w_ack) begin
            mem_req <= 1'b0;
            io_req  <= 1'b0;
            r_cnt   <= w_waitLoad;
            if (w_cycleEnded)
              r_state <= ST_IDLE;
            else begin
              r_rdBuf <= w_rdata;
              r_state <= (w_waitLoad == 4'd0) ? ST_READY : ST_WAITCNT;
            end
          end else if (w_cycleEnded) begin
            r_state <= ST_ABORT;
          end
        end
        ST_WAITCNT: begin
          r_cnt <= (r_cnt == 4'd0) ? 4'd0 : r_cnt - 4'd1;
          if (w_cycleEnded)
            r_state <= ST_IDLE;
          else if (r_cnt <= 4'd1)
            r_state <= ST_READY;
        end
        ST_READY: begin
          if (w_cycleEnded)
            r_state <= ST_IDLE;
        end
        ST_INTA: begin
          if (nIORQ)
            r_state <= ST_IDLE;
        end
        ST_ABORT: begin
          // The target still owes an ack; its data is dropped.
          if (w_ack) begin
            mem_req <= 1'b0;
            io_req  <= 1'b0;
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_z80_bus_responder.sv
//------------------------------------------------------------------------------
// Module  : tb_z80_bus_responder
// Brief   : Directed self-checking bench for z80_bus_responder.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_z80_bus_responder;

  logic        CLK = 1'b0;
  logic        nRESET;
  logic [15:0] A;
  wire  [7:0]  D;
  logic        nM1, nMREQ, nIORQ, nRD, nWR, nRFSH;
  logic        nWAIT;
  logic        mem_req, mem_we, mem_ack;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata, mem_rdata;
  logic        io_req, io_we, io_ack;
  logic [7:0]  io_addr, io_wdata, io_rdata;
  logic [7:0]  int_vec;
  logic        int_vec_en;
  logic        intack;

  logic [7:0]  cpuD;
  logic        cpuDEn;
  assign D = cpuDEn ? cpuD : 8'hzz;

  int passCnt  = 0;
  int totalCnt = 0;
  int memReqRises = 0, ioReqRises = 0, intackCnt = 0;
  int memBase, ioBase, intBase;
  logic prevMemReq = 1'b0, prevIoReq = 1'b0;

  always #5 CLK = ~CLK;

  z80_bus_responder #(.MEM_WAIT(1), .IO_WAIT(0), .INT_VECTOR_DEF(8'hFF)) dut (
    .CLK(CLK), .nRESET(nRESET), .A(A), .D(D),
    .nM1(nM1), .nMREQ(nMREQ), .nIORQ(nIORQ), .nRD(nRD), .nWR(nWR), .nRFSH(nRFSH),
    .nWAIT(nWAIT),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .io_req(io_req), .io_we(io_we), .io_addr(io_addr), .io_wdata(io_wdata),
    .io_rdata(io_rdata), .io_ack(io_ack),
    .int_vec(int_vec), .int_vec_en(int_vec_en), .intack(intack)
  );

  always @(posedge CLK) begin
    prevMemReq <= mem_req;
    prevIoReq  <= io_req;
    if (mem_req && !prevMemReq) memReqRises <= memReqRises + 1;
    if (io_req && !prevIoReq)   ioReqRises  <= ioReqRises + 1;
    if (intack)                 intackCnt   <= intackCnt + 1;
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    totalCnt++;
    assert (obs === exp) passCnt++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic cyc();
    @(negedge CLK);
  endtask

  task automatic busIdle();
    nMREQ = 1'b1; nIORQ = 1'b1; nRD = 1'b1; nWR = 1'b1; nM1 = 1'b1; nRFSH = 1'b1;
    cpuDEn = 1'b0;
  endtask

  initial begin
    busIdle();
    nRESET = 1'b0; A = 16'h0000; cpuD = 8'h00;
    mem_ack = 1'b0; mem_rdata = 8'h00; io_ack = 1'b0; io_rdata = 8'h00;
    int_vec = 8'h00; int_vec_en = 1'b0;
    cyc(); cyc();
    check("rst_nwait", nWAIT, 1);
    check("rst_memreq", mem_req, 0);
    check("rst_ioreq", io_req, 0);
    check("rst_intack", intack, 0);
    check("rst_memaddr", mem_addr, 16'h0000);
    nRESET = 1'b1;
    cyc();

    // Memory read 0x1234, ack three cycles after req, one extra wait.
    memBase = memReqRises;
    A = 16'h1234; nMREQ = 1'b0; nRD = 1'b0;
    #1 check("mrd_nwait_first", nWAIT, 0);
    cyc();
    check("mrd_req", mem_req, 1);
    check("mrd_we", mem_we, 0);
    check("mrd_addr", mem_addr, 16'h1234);
    cyc();
    check("mrd_req_hold", mem_req, 1);
    check("mrd_nwait_hold", nWAIT, 0);
    cyc();
    check("mrd_req_hold2", mem_req, 1);
    mem_ack = 1'b1; mem_rdata = 8'hA5;
    cyc();
    mem_ack = 1'b0; mem_rdata = 8'h00;
    check("mrd_req_drop", mem_req, 0);
    check("mrd_nwait_extra", nWAIT, 0);
    cyc();
    check("mrd_nwait_release", nWAIT, 1);
    check("mrd_d", D, 8'hA5);
    busIdle();
    #1 check("mrd_d_released", (D === 8'hA5), 0);
    cyc();
    check("mrd_one_req", memReqRises - memBase, 1);

    // Memory write 0x3C to 0xFFFF.
    memBase = memReqRises;
    A = 16'hFFFF; cpuD = 8'h3C; cpuDEn = 1'b1; nMREQ = 1'b0; nWR = 1'b0;
    #1 check("mwr_nwait_first", nWAIT, 0);
    cyc();
    check("mwr_req", mem_req, 1);
    check("mwr_we", mem_we, 1);
    check("mwr_addr", mem_addr, 16'hFFFF);
    check("mwr_wdata", mem_wdata, 8'h3C);
    mem_ack = 1'b1;
    cyc();
    mem_ack = 1'b0;
    check("mwr_req_drop", mem_req, 0);
    cyc();
    check("mwr_nwait_release", nWAIT, 1);
    check("mwr_d_cpu", D, 8'h3C);
    busIdle();
    cyc();
    check("mwr_one_req", memReqRises - memBase, 1);

    // OUT (0x01),A with A=0x41.
    ioBase = ioReqRises;
    A = 16'h4101; cpuD = 8'h41; cpuDEn = 1'b1; nIORQ = 1'b0; nWR = 1'b0;
    #1 check("iow_nwait_first", nWAIT, 0);
    cyc();
    check("iow_req", io_req, 1);
    check("iow_we", io_we, 1);
    check("iow_addr", io_addr, 8'h01);
    check("iow_wdata", io_wdata, 8'h41);
    io_ack = 1'b1;
    cyc();
    io_ack = 1'b0;
    check("iow_req_drop", io_req, 0);
    check("iow_nwait_release", nWAIT, 1);
    busIdle();
    cyc();
    check("iow_one_req", ioReqRises - ioBase, 1);

    // IN A,(0x02) returning 0x7E.
    ioBase = ioReqRises;
    A = 16'h4102; nIORQ = 1'b0; nRD = 1'b0;
    cyc();
    check("ior_req", io_req, 1);
    check("ior_we", io_we, 0);
    check("ior_addr", io_addr, 8'h02);
    io_ack = 1'b1; io_rdata = 8'h7E;
    cyc();
    io_ack = 1'b0; io_rdata = 8'h00;
    check("ior_d", D, 8'h7E);
    check("ior_nwait", nWAIT, 1);
    busIdle();
    #1 check("ior_d_released", (D === 8'h7E), 0);
    cyc();
    check("ior_one_req", ioReqRises - ioBase, 1);

    // NOP fetch followed by a refresh cycle.
    memBase = memReqRises;
    A = 16'h0000; nM1 = 1'b0; nMREQ = 1'b0; nRD = 1'b0;
    cyc();
    mem_ack = 1'b1;
    cyc();
    mem_ack = 1'b0;
    cyc();
    busIdle();
    cyc();
    A = 16'h0007; nRFSH = 1'b0; nMREQ = 1'b0;
    #1 check("rfsh_nwait", nWAIT, 1);
    cyc();
    check("rfsh_memreq", mem_req, 0);
    check("rfsh_nwait2", nWAIT, 1);
    busIdle();
    cyc();
    check("rfsh_req_count", memReqRises - memBase, 1);

    // IM2 acknowledge with external vector 0x20.
    ioBase = ioReqRises; intBase = intackCnt;
    int_vec_en = 1'b1; int_vec = 8'h20;
    nM1 = 1'b0;
    cyc();
    nIORQ = 1'b0;
    #1 check("inta_nwait", nWAIT, 1);
    cyc();
    check("inta_pulse", intack, 1);
    check("inta_d", D, 8'h20);
    cyc();
    check("inta_pulse_end", intack, 0);
    check("inta_d_hold", D, 8'h20);
    check("inta_no_ioreq", io_req, 0);
    busIdle();
    #1 check("inta_d_released", (D === 8'h20), 0);
    cyc();
    check("inta_count", intackCnt - intBase, 1);
    check("inta_no_iorises", ioReqRises - ioBase, 0);
    int_vec_en = 1'b0;

    // Strobes rise while in REQ: request held until ack, nothing driven.
    A = 16'h0100; nMREQ = 1'b0; nRD = 1'b0;
    cyc();
    busIdle();
    #1 check("abort_nwait", nWAIT, 1);
    cyc();
    check("abort_req_hold", mem_req, 1);
    mem_ack = 1'b1; mem_rdata = 8'hEE;
    cyc();
    mem_ack = 1'b0; mem_rdata = 8'h00;
    check("abort_req_drop", mem_req, 0);
    check("abort_d", (D === 8'hEE), 0);

    // Reset during REQ with the ack still pending.
    A = 16'h5555; nMREQ = 1'b0; nRD = 1'b0;
    cyc();
    check("rreq_req", mem_req, 1);
    nRESET = 1'b0;
    #1;
    check("rreq_memreq", mem_req, 0);
    check("rreq_nwait", nWAIT, 1);
    check("rreq_addr", mem_addr, 16'h0000);
    busIdle();
    cyc();
    nRESET = 1'b1;
    cyc();
    A = 16'h0042; nMREQ = 1'b0; nRD = 1'b0;
    cyc();
    check("post_rst_req", mem_req, 1);
    check("post_rst_addr", mem_addr, 16'h0042);
    mem_ack = 1'b1; mem_rdata = 8'h5A;
    cyc();
    mem_ack = 1'b0; mem_rdata = 8'h00;
    cyc();
    check("post_rst_d", D, 8'h5A);
    busIdle();
    cyc();

    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule

`default_nettype wire
